axis_iq_interleaver: RTL
========================

// Module: axis_iq_interleaver
// PURPOSE
//  Downstream end of the beamforming multiplier's S2MM output. Joins the separate real and imag
//  AXI-stream pairs (8 x 16-bit samples per beat each) into one interleaved complex stream,
//  two output beats per input pair, ready for one S2MM DMA channel.
//  Handles backpressure, tlast framing, frame counting and real/imag tlast-mismatch detection.
// PARAMETERS
//  SDATA_WIDTH    128  input tdata width per real/imag stream
//  SAMPLE_WIDTH   16   bits per I or Q sample
//  SAMPLES        SDATA_WIDTH/SAMPLE_WIDTH (8)  samples per input beat
//  MDATA_WIDTH    128  output tdata width; must equal SDATA_WIDTH
//  CNT_WIDTH      32   frame counter width
// PORTS
//  clock                in   1      system clock, all logic on rising edge
//  resetn               in   1      synchronous, active-low reset
//  s_axis_real_tvalid   in   1      real stream valid
//  s_axis_real_tready   out  1      real stream ready (always equal to s_axis_imag_tready)
//  s_axis_real_tdata    in   128    8 real samples, sample k at [16k+:16]
//  s_axis_real_tkeep    in   16     byte enables
//  s_axis_real_tlast    in   1      end of frame
//  s_axis_imag_*        in/out      same set for imag stream
//  m_axis_iq_tvalid     out  1      output valid
//  m_axis_iq_tready     in   1      output ready
//  m_axis_iq_tdata      out  128    4 complex samples: I_k at [32k+:16], Q_k at [32k+16+:16]
//  m_axis_iq_tkeep      out  16     byte enables, interleaved like tdata
//  m_axis_iq_tlast      out  1      end of frame, second beat of a pair only
//  err_clear            in   1      clears err_tlast_mismatch
//  err_tlast_mismatch   out  1      sticky: paired beats disagreed on tlast
//  frame_count          out  32     output frames completed (wraps)
// BEHAVIOUR
//  - Reset: state EMPTY, m_axis_iq_tvalid=0, tdata/tkeep/tlast=0, both s_tready=0,
//    err=0, frame_count=0. rdy_en register goes 1 on the first cycle after reset release.
//  - Join: a pair is accepted only when s_real_tvalid & s_imag_tvalid & s_tready.
//    A lone valid on one stream is never consumed.
//  - Accepted pair latches into the hold register {real, imag, keeps, tlast}.
//  - State machine: EMPTY -> LO (on accept). LO -> HI (on m handshake). From HI on m handshake:
//    -> LO if a new pair is accepted in the same cycle, else -> EMPTY.
//  - s_tready = rdy_en & (state==EMPTY | (state==HI & m_axis_iq_tready)). This is the only
//    combinational in->out path. Peak throughput is 1 pair per 2 cycles, so an output beat
//    can be issued every cycle.
//  - m_tvalid = (state!=EMPTY). LO presents samples 0..3, HI presents samples 4..7.
//    Output lane k of a beat is {Q,I} of sample (k + 4*(state==HI)).
//  - tkeep uses the same lane map: 2 real bits then 2 imag bits per sample.
//  - tlast: 0 in LO. In HI it is real_tlast | imag_tlast of the held pair.
//  - Outputs are stable while tvalid & ~tready (AXIS rule). Latency: accept to first output beat
//    is 1 cycle.
//  - Mismatch: accepted pair with real_tlast != imag_tlast sets err_tlast_mismatch (sticky).
//    err_clear clears it. If a mismatch and err_clear occur in the same cycle, set wins.
//  - frame_count +1 on an output handshake with tlast=1; wraps 2^32-1 -> 0.
//  - Reset mid-frame: held data is dropped, all outputs return to reset values next cycle,
//    no partial beat is completed.
// STRUCTURE
//  - Package axis_iq_pkg holds: state enum {EMPTY, LO, HI}, SAMPLE_WIDTH/SAMPLES localparams,
//    and the function iq_lane_pack(real, imag, half) returning 128-bit interleaved data.
//  - Single module, no sub-module. Hold register + 3-state FSM + counters, ~150-200 lines.
// TESTING
//  1. Reset: hold resetn=0 for 5 cycles with both streams valid -> s_tready=0, m_tvalid=0,
//     frame_count=0. s_tready=1 on the 2nd cycle after release.
//  2. Single pair, real_k=0x0100+k, imag_k=0x8000+k, tlast=1, m_tready=1:
//     beat0 = 0x8003_0103_8002_0102_8001_0101_8000_0100 with tlast=0;
//     beat1 = 0x8007_0107_8006_0106_8005_0105_8004_0104 with tlast=1; frame_count=1.
//  3. Stream of 64 pairs (tlast on pair 63), m_tready random 50%: 128 output beats in order,
//     data stable under stall, exactly one tlast, frame_count=1, no data lost.
//  4. Back-to-back with m_tready=1: new pair accepted in the HI-drain cycle -> m_tvalid never
//     drops, 2 beats per pair.
//  5. Lone valid: real_tvalid=1, imag_tvalid=0 for 10 cycles -> no accept, m_tvalid=0.
//     imag valid arrives -> pair accepted that cycle.
//  6. Mismatch: pair with real_tlast=1, imag_tlast=0 -> err=1, out tlast=1 on beat1.
//     err_clear pulse -> err=0. Mismatch and err_clear in the same cycle -> err=1.

Source files
------------

// File: rtl/axis_iq_pkg.sv
// Shared types and lane-packing helpers for the real/imag to interleaved IQ stream joiner.
package axis_iq_pkg;

  localparam int SDATA_WIDTH  = 128;
  localparam int SAMPLE_WIDTH = 16;
  localparam int SAMPLES      = SDATA_WIDTH / SAMPLE_WIDTH;
  localparam int HALF         = SAMPLES / 2;
  localparam int KEEP_WIDTH   = SDATA_WIDTH / 8;
  localparam int SAMPLE_BYTES = SAMPLE_WIDTH / 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } iq_state_t;

  // Output lane k carries {Q,I} of sample k (lower half) or k+HALF (upper half).
  function automatic logic [SDATA_WIDTH-1:0] iq_lane_pack(
    input logic [SDATA_WIDTH-1:0] re,
    input logic [SDATA_WIDTH-1:0] im,
    input logic                   half
  );
    logic [SDATA_WIDTH-1:0] packed_data;
    int j;
    packed_data = '0;
    for (int k = 0; k < HALF; k++) begin
      j = k + (half ? HALF : 0);
      packed_data[2*SAMPLE_WIDTH*k              +: SAMPLE_WIDTH] = re[SAMPLE_WIDTH*j +: SAMPLE_WIDTH];
      packed_data[2*SAMPLE_WIDTH*k+SAMPLE_WIDTH +: SAMPLE_WIDTH] = im[SAMPLE_WIDTH*j +: SAMPLE_WIDTH];
    end
    return packed_data;
  endfunction

  function automatic logic [KEEP_WIDTH-1:0] iq_keep_pack(
    input logic [KEEP_WIDTH-1:0] re_keep,
    input logic [KEEP_WIDTH-1:0] im_keep,
    input logic                  half
  );
    logic [KEEP_WIDTH-1:0] packed_keep;
    int j;
    packed_keep = '0;
    for (int k = 0; k < HALF; k++) begin
      j = k + (half ? HALF : 0);
      packed_keep[2*SAMPLE_BYTES*k              +: SAMPLE_BYTES] = re_keep[SAMPLE_BYTES*j +: SAMPLE_BYTES];
      packed_keep[2*SAMPLE_BYTES*k+SAMPLE_BYTES +: SAMPLE_BYTES] = im_keep[SAMPLE_BYTES*j +: SAMPLE_BYTES];
    end
    return packed_keep;
  endfunction

endpackage

// File: rtl/axis_iq_interleaver.sv
// Joins paired real/imag AXI-streams into one interleaved complex stream, two output beats per pair,
// with frame counting and sticky real/imag tlast-mismatch detection.
module axis_iq_interleaver
  import axis_iq_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   resetn,

  input  logic                   s_axis_real_tvalid,
  output logic                   s_axis_real_tready,
  input  logic [SDATA_WIDTH-1:0] s_axis_real_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_axis_real_tkeep,
  input  logic                   s_axis_real_tlast,

  input  logic                   s_axis_imag_tvalid,
  output logic                   s_axis_imag_tready,
  input  logic [SDATA_WIDTH-1:0] s_axis_imag_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_axis_imag_tkeep,
  input  logic                   s_axis_imag_tlast,

  output logic                   m_axis_iq_tvalid,
  input  logic                   m_axis_iq_tready,
  output logic [SDATA_WIDTH-1:0] m_axis_iq_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_iq_tkeep,
  output logic                   m_axis_iq_tlast,

  input  logic                   err_clear,
  output logic                   err_tlast_mismatch,
  output logic [CNT_WIDTH-1:0]   frame_count
);

  iq_state_t              state, state_nxt;
  logic                   rdy_en;
  logic [SDATA_WIDTH-1:0] hold_real, hold_imag;
  logic [KEEP_WIDTH-1:0]  hold_real_keep, hold_imag_keep;
  logic                   hold_tlast;

  logic s_tready;
  logic accept;
  logic m_hs;
  logic half;

  assign s_tready           = rdy_en & ((state == EMPTY) | ((state == HI) & m_axis_iq_tready));
  assign s_axis_real_tready = s_tready;
  assign s_axis_imag_tready = s_tready;
  assign accept             = s_tready & s_axis_real_tvalid & s_axis_imag_tvalid;

  assign half             = (state == HI);
  assign m_axis_iq_tvalid = (state != EMPTY);
  assign m_hs             = m_axis_iq_tvalid & m_axis_iq_tready;

  // Outputs come straight from held registers, so they cannot move while a beat is stalled.
  assign m_axis_iq_tdata = m_axis_iq_tvalid ? iq_lane_pack(hold_real, hold_imag, half) : '0;
  assign m_axis_iq_tkeep = m_axis_iq_tvalid ? iq_keep_pack(hold_real_keep, hold_imag_keep, half) : '0;
  assign m_axis_iq_tlast = half & hold_tlast;

  always_comb begin
    // NOTE: next-state gets a default first so no path through the case infers a latch.
    state_nxt = state;
    unique case (state)
      EMPTY:   if (accept) state_nxt = LO;
      LO:      if (m_hs)   state_nxt = HI;
      HI:      if (m_hs)   state_nxt = accept ? LO : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= EMPTY;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
    end
  end

  // NOTE: the hold register is reset too, because a mid-frame reset must drop held data outright.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hold_real      <= '0;
      hold_imag      <= '0;
      hold_real_keep <= '0;
      hold_imag_keep <= '0;
      hold_tlast     <= 1'b0;
    end else if (accept) begin
      hold_real      <= s_axis_real_tdata;
      hold_imag      <= s_axis_imag_tdata;
      hold_real_keep <= s_axis_real_tkeep;
      hold_imag_keep <= s_axis_imag_tkeep;
      hold_tlast     <= s_axis_real_tlast | s_axis_imag_tlast;
    end
  end

  // A fresh mismatch outranks a simultaneous clear so the event is never lost.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      err_tlast_mismatch <= 1'b0;
    end else if (accept && (s_axis_real_tlast != s_axis_imag_tlast)) begin
      err_tlast_mismatch <= 1'b1;
    end else if (err_clear) begin
      err_tlast_mismatch <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      frame_count <= '0;
    end else if (m_hs && m_axis_iq_tlast) begin
      frame_count <= frame_count + 1'b1;
    end
  end

endmodule
